// File: rtl/pr_pkg.sv
// Shared definitions for the inter-stage pipeline registers: the ID/EX
// control-bundle layout, the default bubble value and the skid-stage states.
package pr_pkg;

  // ID/EX control bundle layout, LSB first
  localparam int ALU_SEL_W   = 5;
  localparam int ALU_SEL_LSB = 0;
  localparam int OPA_SEL_W   = 1;
  localparam int OPA_SEL_LSB = ALU_SEL_LSB + ALU_SEL_W;
  localparam int OPB_SEL_W   = 1;
  localparam int OPB_SEL_LSB = OPA_SEL_LSB + OPA_SEL_W;
  localparam int REG_WE_W    = 1;
  localparam int REG_WE_LSB  = OPB_SEL_LSB + OPB_SEL_W;
  localparam int MEM_WR_W    = 3;
  localparam int MEM_WR_LSB  = REG_WE_LSB + REG_WE_W;
  localparam int MEM_RD_W    = 4;
  localparam int MEM_RD_LSB  = MEM_WR_LSB + MEM_WR_W;
  localparam int BRANCH_W    = 4;
  localparam int BRANCH_LSB  = MEM_RD_LSB + MEM_RD_W;
  localparam int WB_SEL_W    = 2;
  localparam int WB_SEL_LSB  = BRANCH_LSB + BRANCH_W;

  localparam int CTRL_W_IDEX = WB_SEL_LSB + WB_SEL_W;  // 21

  // All enables low: a bubble can never write a register or memory
  localparam logic [CTRL_W_IDEX-1:0] CTRL_BUBBLE_IDEX = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pr_state_e;

  function automatic logic [1:0] occ_of(input logic head_v, input logic skid_v);
    return {1'b0, head_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pr_slot.sv
// One storage entry: valid bit plus data/ctrl payload. Clear beats load, so
// an entry arriving in a flush cycle is dropped.
module pr_slot
  import pr_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = CTRL_W_IDEX
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          clear,
  input  logic [DW-1:0] wdata,
  input  logic [CW-1:0] wctrl,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [CW-1:0] ctrl
);

  // Entry register; payload is only rewritten on load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= wdata;
      ctrl  <= wctrl;
    end
  end

endmodule

// File: rtl/pr_pipe_stage.sv
// Generic valid/ready pipeline register. SKID=1: two-entry skid buffer with
// a registered IN_READY. SKID=0: single stall register, combinational ready.
module pr_pipe_stage
  import pr_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    CTRL_WIDTH  = CTRL_W_IDEX,
  parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = '0,
  parameter int                    SKID        = 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic [CTRL_WIDTH-1:0] IN_CTRL,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [CTRL_WIDTH-1:0] OUT_CTRL,
  input  logic                  FLUSH,
  output logic [1:0]            OCC
);

  logic                  in_ready, in_fire, out_fire;
  logic                  head_load, head_clear, head_from_skid;
  logic                  head_valid, skid_valid;
  logic [DATA_WIDTH-1:0] head_data, skid_data, head_wdata;
  logic [CTRL_WIDTH-1:0] head_ctrl, skid_ctrl, head_wctrl;

  assign in_fire    = IN_VALID & in_ready;
  assign out_fire   = head_valid & OUT_READY;
  assign head_wdata = head_from_skid ? skid_data : IN_DATA;
  assign head_wctrl = head_from_skid ? skid_ctrl : IN_CTRL;

  pr_slot #(.DW(DATA_WIDTH), .CW(CTRL_WIDTH)) u_head (
    .clk   (CLK),
    .rst_n (RESET_N),
    .load  (head_load),
    .clear (head_clear),
    .wdata (head_wdata),
    .wctrl (head_wctrl),
    .valid (head_valid),
    .data  (head_data),
    .ctrl  (head_ctrl)
  );

  if (SKID != 0) begin : g_skid
    pr_state_e state, state_nxt;
    logic      skid_load, skid_clear, rdy_q;

    // State is fully captured by the two valid bits
    always_comb begin
      state = ST_EMPTY;
      if (skid_valid)      state = ST_FULL;
      else if (head_valid) state = ST_ONE;
    end

    // Next state; flush always empties the stage
    always_comb begin
      state_nxt = state;
      if (FLUSH) begin
        state_nxt = ST_EMPTY;
      end else begin
        case (state)
          ST_EMPTY: if (in_fire) state_nxt = ST_ONE;
          ST_ONE: begin
            if (in_fire && !out_fire)      state_nxt = ST_FULL;
            else if (!in_fire && out_fire) state_nxt = ST_EMPTY;
          end
          ST_FULL:  if (out_fire) state_nxt = ST_ONE;
          default:  state_nxt = ST_EMPTY;
        endcase
      end
    end

    // Slot controls; slot clear has priority over load for flush
    always_comb begin
      head_load      = 1'b0;
      head_from_skid = 1'b0;
      head_clear     = FLUSH;
      skid_load      = 1'b0;
      skid_clear     = FLUSH;
      case (state)
        ST_EMPTY: head_load = in_fire;
        ST_ONE: begin
          head_load  = in_fire & out_fire;
          skid_load  = in_fire & ~out_fire;
          head_clear = FLUSH | (out_fire & ~in_fire);
        end
        ST_FULL: begin
          head_load      = out_fire;
          head_from_skid = out_fire;
          skid_clear     = FLUSH | out_fire;
        end
        default: ;
      endcase
    end

    // Registered ready, looking ahead to the next state so it never lags
    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) rdy_q <= 1'b1;
      else          rdy_q <= (state_nxt != ST_FULL);
    end

    assign in_ready = rdy_q;

    pr_slot #(.DW(DATA_WIDTH), .CW(CTRL_WIDTH)) u_skid (
      .clk   (CLK),
      .rst_n (RESET_N),
      .load  (skid_load),
      .clear (skid_clear),
      .wdata (IN_DATA),
      .wctrl (IN_CTRL),
      .valid (skid_valid),
      .data  (skid_data),
      .ctrl  (skid_ctrl)
    );
  end else begin : g_plain
    assign in_ready       = ~head_valid | OUT_READY;
    assign head_load      = in_fire;
    assign head_from_skid = 1'b0;
    assign head_clear     = FLUSH | (out_fire & ~in_fire);
    assign skid_valid     = 1'b0;
    assign skid_data      = '0;
    assign skid_ctrl      = '0;
  end

  assign IN_READY  = in_ready;
  assign OUT_VALID = head_valid;
  assign OUT_DATA  = head_data;
  assign OUT_CTRL  = head_valid ? head_ctrl : CTRL_BUBBLE;
  assign OCC       = occ_of(head_valid, skid_valid);

endmodule

// File: tb/tb_pr_pipe_stage.sv
// Bench for pr_pipe_stage: one skid instance and one plain instance share the
// stimulus; each is checked every cycle against a queue model of its stage.
module tb_pr_pipe_stage;

  typedef logic [52:0] ent_t;  // {data[31:0], ctrl[20:0]}

  logic        clk, rst_n;
  logic        iv, ordy, fl;
  logic [31:0] id;
  logic [20:0] ictrl;

  logic        r1, v1, r0, v0;
  logic [31:0] d1, d0;
  logic [20:0] c1, c0;
  logic [1:0]  o1, o0;

  int   n_cmp, n_bad;
  bit   cmp_en;
  ent_t q1[$], q0[$];
  bit   rdy1;

  pr_pipe_stage #(.SKID(1)) u1 (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(iv), .IN_READY(r1), .IN_DATA(id),
    .IN_CTRL(ictrl), .OUT_VALID(v1), .OUT_READY(ordy), .OUT_DATA(d1),
    .OUT_CTRL(c1), .FLUSH(fl), .OCC(o1)
  );

  pr_pipe_stage #(.SKID(0)) u0 (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(iv), .IN_READY(r0), .IN_DATA(id),
    .IN_CTRL(ictrl), .OUT_VALID(v0), .OUT_READY(ordy), .OUT_DATA(d0),
    .OUT_CTRL(c0), .FLUSH(fl), .OCC(o0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Queue model: a stage of capacity 2 (skid) or 1 (plain)
  task automatic model_update();
    bit inf, of;
    if (!rst_n) return;
    inf = iv && rdy1;
    of  = (q1.size() > 0) && ordy;
    if (fl) q1.delete();
    else begin
      if (of)  void'(q1.pop_front());
      if (inf) q1.push_back({id, ictrl});
    end
    rdy1 = (q1.size() < 2);
    inf = iv && ((q0.size() == 0) || ordy);
    of  = (q0.size() > 0) && ordy;
    if (fl) q0.delete();
    else begin
      if (of)  void'(q0.pop_front());
      if (inf) q0.push_back({id, ictrl});
    end
  endtask

  task automatic model_reset();
    q1.delete();
    q0.delete();
    rdy1 = 1'b1;
  endtask

  // One clock cycle: drive, let the compare process sample, step the model
  task automatic cyc(input bit v, input logic [31:0] d, input logic [20:0] c,
                     input bit r, input bit f);
    iv = v; id = d; ictrl = c; ordy = r; fl = f;
    @(negedge clk);
    #1 model_update();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of both instances against the model
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("u1 valid", 64'(v1), 64'(q1.size() > 0));
      chk("u1 occ",   64'(o1), 64'(q1.size()));
      chk("u1 ready", 64'(r1), 64'(rdy1));
      chk("u1 ctrl",  64'(c1), (q1.size() > 0) ? 64'(q1[0][20:0]) : 64'(0));
      if (q1.size() > 0) chk("u1 data", 64'(d1), 64'(q1[0][52:21]));
      chk("u0 valid", 64'(v0), 64'(q0.size() > 0));
      chk("u0 occ",   64'(o0), 64'(q0.size()));
      chk("u0 ready", 64'(r0), 64'((q0.size() == 0) || ordy));
      chk("u0 ctrl",  64'(c0), (q0.size() > 0) ? 64'(q0[0][20:0]) : 64'(0));
      if (q0.size() > 0) chk("u0 data", 64'(d0), 64'(q0[0][52:21]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    n_cmp = 0; n_bad = 0; cmp_en = 1'b0;
    iv = 0; id = '0; ictrl = '0; ordy = 0; fl = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst u1 valid", 64'(v1), 64'(0));
    chk("rst u1 occ",   64'(o1), 64'(0));
    chk("rst u1 ready", 64'(r1), 64'(1));
    chk("rst u1 data",  64'(d1), 64'(0));
    chk("rst u1 ctrl",  64'(c1), 64'(0));
    chk("rst u0 ready", 64'(r0), 64'(1));
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Streaming 1..8 back to back
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 32'(i), 21'h0_1234, 1, 0);
      chk("stream u1 data", 64'(d1), 64'(i));
      chk("stream u0 data", 64'(d0), 64'(i));
      chk("stream u1 occ",  64'(o1), 64'(1));
      chk("stream u1 ready", 64'(r1), 64'(1));
    end

    // Backpressure: OUT_READY low for 3 cycles
    d = 32'd10;
    for (int k = 0; k < 12; k++) begin
      bit r, acc;
      r = !(k >= 2 && k < 5);
      acc = rdy1;
      if (k == 2) begin
        ordy = 1'b0;
        #1;
        chk("bp u0 ready same cycle", 64'(r0), 64'(0));
        chk("bp u1 ready still up",   64'(r1), 64'(1));
      end
      cyc(1, d, 21'h0_0055, r, 0);
      if (k == 2) begin
        chk("bp u1 occ 2",     64'(o1), 64'(2));
        chk("bp u1 ready low", 64'(r1), 64'(0));
        chk("bp u0 occ 1",     64'(o0), 64'(1));
      end
      if (acc) d++;
    end

    // Flush while FULL, with 0xAA on the input
    cyc(1, d, 21'h0_0077, 0, 0);
    chk("pre-flush u1 occ", 64'(o1), 64'(2));
    cyc(1, 32'hAA, 21'h1F_FFFF, 0, 1);
    chk("flush u1 valid", 64'(v1), 64'(0));
    chk("flush u1 ctrl",  64'(c1), 64'(0));
    chk("flush u1 occ",   64'(o1), 64'(0));
    chk("flush u1 ready", 64'(r1), 64'(1));
    chk("flush u0 valid", 64'(v0), 64'(0));

    // Bubble masking with all control bits set
    cyc(1, 32'd20, 21'h1F_FFFF, 1, 0);
    cyc(0, 32'd21, 21'h1F_FFFF, 1, 0);
    chk("bubble u1 ctrl", 64'(c1), 64'(0));
    chk("bubble u0 ctrl", 64'(c0), 64'(0));
    cyc(1, 32'd22, 21'h1F_FFFF, 1, 0);
    chk("post-bubble u1 ctrl", 64'(c1), 64'h1F_FFFF);
    chk("post-bubble u1 data", 64'(d1), 64'd22);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      cyc($urandom_range(3, 0) != 0, $urandom, 21'($urandom),
          $urandom_range(2, 0) != 0, $urandom_range(15, 0) == 0);
    end

    // Asynchronous reset while FULL
    cyc(1, 32'd30, 21'h0_0101, 1, 0);
    cyc(1, 32'd31, 21'h0_0202, 0, 0);
    chk("pre-reset u1 occ", 64'(o1), 64'(2));
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async rst u1 valid", 64'(v1), 64'(0));
    chk("async rst u1 occ",   64'(o1), 64'(0));
    chk("async rst u1 ready", 64'(r1), 64'(1));
    chk("async rst u1 data",  64'(d1), 64'(0));
    chk("async rst u1 ctrl",  64'(c1), 64'(0));
    chk("async rst u0 data",  64'(d0), 64'(0));
    cyc(1, 32'd40, 21'h0_0303, 1, 0);
    cyc(1, 32'd41, 21'h0_0303, 1, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cyc(1, 32'(50 + i), 21'h0_0404, 1, 0);
    chk("post-reset u1 data", 64'(d1), 64'd55);

    cyc(0, '0, '0, 1, 0);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
